// File: rtl/toy_pkg.sv
// Shared RISC_toy definitions: instruction/PC widths, bubble encoding and
// the fetch-stage state type.
package toy_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        FS_RUN,
        FS_HOLD
    } fetch_state_e;

    // One fetched word together with the PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_word_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} holding buffer that catches the word returning from
// memory while IF/ID is frozen by a stall.
module fetch_skid
    import toy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  fetch_word_t din,
    output logic        valid,
    output fetch_word_t dout
);

    logic        valid_q, valid_d;
    fetch_word_t data_q, data_d;

    // Clear (redirect flush) dominates a load, which dominates a drain.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-cycle memory requests,
// absorbs stalls through a one-entry skid and inserts bubbles on redirect.
module fetch_stage
    import toy_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RSTn,
    output logic        IREQ,
    output logic [31:0] IADDR,
    input  logic [31:0] IRDATA,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTR_D,
    output logic [31:0] PC_D,
    output logic        VALID_D
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_f_q, pc_f_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    fetch_word_t     ifid_q, ifid_d;
    logic            ifid_v_q, ifid_v_d;

    logic            req_c;
    logic [PC_W-1:0] addr_c;
    logic            skid_load, skid_drain, skid_clear;
    logic            skid_valid;
    fetch_word_t     skid_word;
    fetch_word_t     ret_word;

    // Request side is combinational so the new target issues in the redirect cycle.
    always_comb begin
        req_c  = RSTn & (REDIRECT | ~STALL);
        addr_c = (RSTn & REDIRECT) ? align_pc(REDIRECT_PC) : pc_f_q;
    end

    assign IREQ  = req_c;
    assign IADDR = addr_c;

    assign ret_word.instr = IRDATA;
    assign ret_word.pc    = pend_pc_q;

    fetch_skid u_skid (
        .clk   (CLK),
        .rst_n (RSTn),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (skid_clear),
        .din   (ret_word),
        .valid (skid_valid),
        .dout  (skid_word)
    );

    // Next-state logic: REDIRECT > STALL > normal flow.
    always_comb begin
        state_d    = state_q;
        pc_f_d     = pc_f_q;
        pend_d     = 1'b0;
        pend_pc_d  = pend_pc_q;
        ifid_d     = ifid_q;
        ifid_v_d   = ifid_v_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (req_c) begin
            pc_f_d    = addr_c + PC_W'(PC_STEP);
            pend_d    = 1'b1;
            pend_pc_d = addr_c;
        end

        if (REDIRECT) begin
            skid_clear   = 1'b1;
            ifid_d.instr = NOP_INSTR;
            ifid_d.pc    = '0;
            ifid_v_d     = 1'b0;
            state_d      = FS_RUN;
        end else if (STALL) begin
            state_d   = FS_HOLD;
            skid_load = pend_q;
        end else begin
            state_d = FS_RUN;
            if (skid_valid) begin
                ifid_d     = skid_word;
                ifid_v_d   = 1'b1;
                skid_drain = 1'b1;
            end else if (pend_q) begin
                ifid_d   = ret_word;
                ifid_v_d = 1'b1;
            end else begin
                ifid_d.instr = NOP_INSTR;
                ifid_d.pc    = '0;
                ifid_v_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= FS_RUN;
            pc_f_q    <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
            ifid_q    <= '0;
            ifid_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_f_q    <= pc_f_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            ifid_q    <= ifid_d;
            ifid_v_q  <= ifid_v_d;
        end
    end

    assign INSTR_D = ifid_q.instr;
    assign PC_D    = ifid_q.pc;
    assign VALID_D = ifid_v_q;

    // A second word arriving while the skid is occupied would be lost.
    a_skid_single: assert property (@(posedge CLK) disable iff (!RSTn)
        !(skid_load && skid_valid));

    a_skid_hold: assert property (@(posedge CLK) disable iff (!RSTn)
        skid_valid |-> (state_q == FS_HOLD));

    a_no_pend_with_skid: assert property (@(posedge CLK) disable iff (!RSTn)
        (!STALL && !REDIRECT) |-> !(pend_q && skid_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized STALL/REDIRECT
// traffic, checked against a transaction-level queue model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rstn;
    logic        ireq;
    logic [31:0] iaddr;
    logic [31:0] irdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] key      = 32'h0;

    // Model: fetched-but-undelivered PCs, next sequential PC, and IF/ID contents.
    logic [31:0] m_q[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic        m_v;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .CLK         (clk),
        .RSTn        (rstn),
        .IREQ        (ireq),
        .IADDR       (iaddr),
        .IRDATA      (irdata),
        .STALL       (stall),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc),
        .INSTR_D     (instr_d),
        .PC_D        (pc_d),
        .VALID_D     (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: word = address ^ key; garbage when not requested.
    always @(posedge clk) begin
        if (ireq) irdata <= iaddr ^ key;
        else      irdata <= $urandom();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_instr"}, instr_d, m_instr);
        chk({tag, "_pc"}, pc_d, m_pc);
        chk({tag, "_valid"}, {31'b0, valid_d}, {31'b0, m_v});
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = RST_PC;
        m_instr    = 32'h0;
        m_pc       = 32'h0;
        m_v        = 1'b0;
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic do_reset();
        rstn = 1'b0;
        #2;
        model_reset();
        chk_outputs("rst");
        chk("rst_ireq", {31'b0, ireq}, 32'h0);
        chk("rst_iaddr", iaddr, RST_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock cycle: drive at negedge, check request, advance, check IF/ID.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc);
        logic [31:0] exp_addr;
        logic [31:0] p;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
        exp_addr = r ? (rpc & 32'hFFFF_FFFC) : m_fetch_pc;
        chk("ireq", {31'b0, ireq}, {31'b0, (r | ~s)});
        chk("iaddr", iaddr, exp_addr);
        @(posedge clk);
        if (r) begin
            m_q.delete();
            m_instr = 32'h0;
            m_pc    = 32'h0;
            m_v     = 1'b0;
            m_q.push_back(exp_addr);
            m_fetch_pc = exp_addr + 32'd4;
        end else if (!s) begin
            if (m_q.size() > 0) begin
                p       = m_q.pop_front();
                m_instr = p ^ key;
                m_pc    = p;
                m_v     = 1'b1;
            end else begin
                m_instr = 32'h0;
                m_pc    = 32'h0;
                m_v     = 1'b0;
            end
            m_q.push_back(m_fetch_pc);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        #1;
        chk_outputs("ifid");
        @(negedge clk);
    endtask

    initial begin
        rstn        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Streaming from reset: bubble, then 0, 4, 8.
        repeat (4) step(1'b0, 1'b0, 32'h0);
        chk("stream_8", instr_d, 32'h8);
        chk("stream_pc_eq", pc_d, instr_d);

        // Three-cycle stall holding 0x8, then 0xC, 0x10.
        repeat (3) step(1'b1, 1'b0, 32'h0);
        chk("stall_hold", instr_d, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        chk("stall_rel_c", instr_d, 32'hC);
        step(1'b0, 1'b0, 32'h0);
        chk("stall_rel_10", instr_d, 32'h10);

        // Redirect to unaligned 0x103: bubble, 0x100, 0x104.
        step(1'b0, 1'b1, 32'h103);
        chk("redir_bubble", {31'b0, valid_d}, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_100", instr_d, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        chk("redir_104", instr_d, 32'h104);

        // Redirect during a stall with the skid full.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h200);
        chk("rs_bubble", instr_d, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("rs_200", instr_d, 32'h200);

        // PC wrap.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_fffc", instr_d, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("wrap_0", instr_d, 32'h0);
        chk("wrap_0_valid", {31'b0, valid_d}, 32'h1);

        // Async reset in the middle of a stall with the skid full.
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("restart_pc", pc_d, RST_PC);
        chk("restart_valid", {31'b0, valid_d}, 32'h1);

        // Randomized traffic with a non-trivial memory image.
        key = $urandom();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
